// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-addressable controller in front of the 256x32 RAM:
// access sizes, FSM states, read-wait default and the alignment rule.
package mem_ctrl_pkg;

    localparam int unsigned RD_WAIT_DEF = 2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_ACK  = 2'b11
    } mem_state_e;

    // Reserved size and any access not naturally aligned to its own width is refused.
    function automatic logic access_bad(input mem_size_e size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lane[0];
            SZ_WORD: return (lane != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extract/extend a load from a RAM word, and merge
// sub-word store data into a RAM word for read-modify-write.
module mem_lane_align
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] rword_i,
    input  logic [1:0]  lane_i,
    input  mem_size_e   size_i,
    input  logic        sign_i,
    input  logic [15:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_w;
    logic [15:0] half_w;

    assign byte_w = rword_i[{lane_i, 3'b000} +: 8];
    assign half_w = rword_i[{lane_i[1], 4'b0000} +: 16];

    always_comb begin
        load_o  = rword_i;
        merge_o = rword_i;
        case (size_i)
            SZ_BYTE: begin
                load_o = {{24{sign_i & byte_w[7]}}, byte_w};
                merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                load_o = {{16{sign_i & half_w[15]}}, half_w};
                merge_o[{lane_i[1], 4'b0000} +: 16] = wdata_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Single-port RAM access controller: byte/half/word loads and stores with
// read-modify-write for sub-word stores and a programmable read wait.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | waiting for req; ack/err of the previous access shown here
//   ST_RD   | ram_adr held, wait_q counts down to the ram_dout sample
//   ST_WR   | ram_wr high for this single cycle
//   ST_ACK  | access finished; ack/err register on leaving this state
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned RD_WAIT = RD_WAIT_DEF
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [9:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy,
    output logic [7:0]  ram_adr,
    output logic [31:0] ram_din,
    output logic        ram_wr,
    input  logic [31:0] ram_dout
);

    mem_state_e  state_q;
    mem_size_e   size_q;
    logic        we_q, sign_q, bad_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;
    logic [1:0]  wait_q;
    logic [31:0] rdata_q, ram_din_q;
    logic [7:0]  ram_adr_q;
    logic        ack_q, err_q, busy_q, ram_wr_q;
    logic [31:0] load_w, merge_w;
    mem_size_e   size_in;

    assign size_in = mem_size_e'(size);

    mem_lane_align u_align (
        .rword_i (ram_dout),
        .lane_i  (lane_q),
        .size_i  (size_q),
        .sign_i  (sign_q),
        .wdata_i (wdata_q),
        .load_o  (load_w),
        .merge_o (merge_w)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            size_q    <= SZ_BYTE;
            we_q      <= 1'b0;
            sign_q    <= 1'b0;
            bad_q     <= 1'b0;
            lane_q    <= 2'b00;
            wdata_q   <= '0;
            wait_q    <= '0;
            rdata_q   <= '0;
            ram_din_q <= '0;
            ram_adr_q <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            ram_wr_q  <= 1'b0;
        end else begin
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            ram_wr_q <= 1'b0;
            if (ack_q) busy_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    // The ack cycle is spent in IDLE, so a new request waits one more cycle.
                    if (req && !ack_q) begin
                        busy_q  <= 1'b1;
                        we_q    <= we;
                        size_q  <= size_in;
                        sign_q  <= sign;
                        lane_q  <= addr[1:0];
                        wdata_q <= wdata[15:0];
                        if (access_bad(size_in, addr[1:0])) begin
                            bad_q   <= 1'b1;
                            state_q <= ST_ACK;
                        end else if (we && size_in == SZ_WORD) begin
                            bad_q     <= 1'b0;
                            ram_adr_q <= addr[9:2];
                            ram_din_q <= wdata;
                            ram_wr_q  <= 1'b1;
                            state_q   <= ST_WR;
                        end else begin
                            bad_q     <= 1'b0;
                            ram_adr_q <= addr[9:2];
                            wait_q    <= 2'(RD_WAIT - 1);
                            state_q   <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (wait_q == 2'd0) begin
                        if (we_q) begin
                            ram_din_q <= merge_w;
                            ram_wr_q  <= 1'b1;
                            state_q   <= ST_WR;
                        end else begin
                            rdata_q <= load_w;
                            state_q <= ST_ACK;
                        end
                    end else begin
                        wait_q <= wait_q - 2'd1;
                    end
                end
                ST_WR: state_q <= ST_ACK;
                ST_ACK: begin
                    ack_q   <= 1'b1;
                    err_q   <= bad_q;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rdata   = rdata_q;
    assign ack     = ack_q;
    assign err     = err_q;
    assign busy    = busy_q;
    assign ram_adr = ram_adr_q;
    assign ram_din = ram_din_q;
    assign ram_wr  = ram_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed scenarios plus randomized accesses checked against
// an arithmetic model of memory contents, load results and latencies.
module tb_mem_ctrl;

    localparam int RD_WAIT = 2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req, we, sign;
    logic [1:0]  size;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack, err, busy;
    logic [7:0]  ram_adr;
    logic [31:0] ram_din;
    logic        ram_wr;
    logic [31:0] ram_dout;

    logic [31:0] mem [256];
    int          wr_cnt = 0;

    logic [31:0] model_mem [256];
    logic [31:0] model_rdata;
    logic [7:0]  model_adr;

    int n_vec = 0;
    int n_bad = 0;

    mem_ctrl #(.RD_WAIT(RD_WAIT)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .req      (req),
        .we       (we),
        .size     (size),
        .sign     (sign),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ack      (ack),
        .err      (err),
        .busy     (busy),
        .ram_adr  (ram_adr),
        .ram_din  (ram_din),
        .ram_wr   (ram_wr),
        .ram_dout (ram_dout)
    );

    always #5 clock = ~clock;

    assign ram_dout = mem[ram_adr];

    always @(posedge clock) begin
        if (ram_wr) begin
            mem[ram_adr] = ram_din;
            wr_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] word, input int lane,
                                               input int nbytes, input bit sgn);
        longint v;
        int     bits;
        bits = nbytes * 8;
        v = longint'(word >> (8 * lane));
        if (bits < 32) begin
            v = v % (longint'(1) << bits);
            if (sgn && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
        end
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] word, input int lane,
                                                input int nbytes, input logic [31:0] wd);
        logic [31:0] r;
        int          p;
        r = word;
        for (int i = 0; i < nbytes; i++) begin
            p = 8 * (lane + i);
            r = (r & ~(32'hFF << p)) | (((wd >> (8 * i)) & 32'hFF) << p);
        end
        return r;
    endfunction

    task automatic preload(input int w, input logic [31:0] val);
        mem[w]       = val;
        model_mem[w] = val;
    endtask

    task automatic run_txn(input logic t_we, input logic [1:0] t_size, input logic t_sign,
                           input logic [9:0] t_addr, input logic [31:0] t_wdata);
        int lane, w, nb, exp_lat, exp_wr, lat, wr0;
        bit bad, accepted;
        lane = int'(t_addr[1:0]);
        w    = int'(t_addr[9:2]);
        nb   = (t_size == 2'd0) ? 1 : (t_size == 2'd1) ? 2 : 4;
        bad  = (t_size == 2'd3) || ((int'(t_addr) % nb) != 0);
        exp_wr = 0;
        if (bad) exp_lat = 1;
        else if (t_we && nb == 4) begin
            exp_lat = 2; exp_wr = 1;
            model_mem[w] = t_wdata;
        end else if (t_we) begin
            exp_lat = RD_WAIT + 2; exp_wr = 1;
            model_mem[w] = model_store(model_mem[w], lane, nb, t_wdata);
        end else begin
            exp_lat = RD_WAIT + 1;
            model_rdata = model_load(model_mem[w], lane, nb, t_sign);
        end
        if (!bad) model_adr = t_addr[9:2];

        wr0 = wr_cnt;
        @(negedge clock);
        req = 1'b1; we = t_we; size = t_size; sign = t_sign; addr = t_addr; wdata = t_wdata;
        accepted = 1'b0;
        for (int k = 0; k < 10 && !accepted; k++) begin
            @(negedge clock);
            accepted = busy;
        end
        req = 1'b0;
        if (!accepted) begin
            chk("accept", 32'(busy), 32'd1);
            return;
        end
        lat = 0;
        while (!ack && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("err", 32'(err), 32'(bad));
        chk("busy_at_ack", 32'(busy), 32'd1);
        chk("rdata", rdata, model_rdata);
        chk("ram_adr", 32'(ram_adr), 32'(model_adr));
        chk("wr_pulses", 32'(wr_cnt - wr0), 32'(exp_wr));
        chk("ram_word", mem[w], model_mem[w]);
        @(negedge clock);
        chk("ack_one_cycle", 32'(ack), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        int acks, low_cnt, wr0;
        logic [1:0] rs;
        logic [9:0] ra;

        reset_n = 1'b0;
        req = 1'b0; we = 1'b0; size = 2'd0; sign = 1'b0; addr = '0; wdata = '0;
        for (int i = 0; i < 256; i++) preload(i, $urandom);
        model_rdata = '0;
        model_adr   = '0;
        repeat (3) @(negedge clock);
        chk("rst_outs", {29'd0, ack, err, busy}, 32'd0);
        chk("rst_ctl", {23'd0, ram_wr, ram_adr}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_din", ram_din, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        run_txn(1'b1, 2'd2, 1'b0, 10'h004, 32'hDEADBEEF);
        run_txn(1'b0, 2'd2, 1'b0, 10'h004, 32'h0);
        preload(1, 32'h11223344);
        run_txn(1'b1, 2'd0, 1'b0, 10'h006, 32'h000000A5);
        run_txn(1'b0, 2'd0, 1'b1, 10'h006, 32'h0);
        run_txn(1'b0, 2'd0, 1'b0, 10'h006, 32'h0);
        preload(255, 32'h0);
        run_txn(1'b1, 2'd1, 1'b0, 10'h3FE, 32'h00008001);
        run_txn(1'b0, 2'd1, 1'b1, 10'h3FE, 32'h0);
        run_txn(1'b0, 2'd2, 1'b0, 10'h002, 32'h0);
        run_txn(1'b0, 2'd3, 1'b0, 10'h004, 32'h0);
        run_txn(1'b1, 2'd1, 1'b0, 10'h005, 32'h1234);

        // Reset during the read phase of a byte store.
        preload(16, 32'hCAFEF00D);
        wr0 = wr_cnt;
        @(negedge clock);
        req = 1'b1; we = 1'b1; size = 2'd0; sign = 1'b0; addr = 10'h041; wdata = 32'h77;
        @(negedge clock);
        req = 1'b0;
        chk("rst_busy_pre", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_outs", {29'd0, ack, err, busy}, 32'd0);
        chk("rst_mid_ctl", {23'd0, ram_wr, ram_adr}, 32'd0);
        chk("rst_mid_rdata", rdata, 32'd0);
        chk("rst_mid_din", ram_din, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        model_rdata = '0;
        model_adr   = '0;
        acks = 0;
        repeat (6) begin
            @(negedge clock);
            if (ack) acks++;
        end
        chk("rst_no_ack", 32'(acks), 32'd0);
        chk("rst_no_wr", 32'(wr_cnt - wr0), 32'd0);
        chk("rst_word", mem[16], 32'hCAFEF00D);
        run_txn(1'b0, 2'd2, 1'b0, 10'h040, 32'h0);

        // Three word stores with req held high.
        wr0 = wr_cnt;
        acks = 0;
        low_cnt = 0;
        @(negedge clock);
        req = 1'b1; we = 1'b1; size = 2'd2; sign = 1'b0; addr = 10'h020; wdata = 32'h5A5AC3C3;
        for (int k = 0; k < 40 && acks < 3; k++) begin
            @(negedge clock);
            if (ack) acks++;
            if (acks > 0 && acks < 3 && !busy) low_cnt++;
        end
        req = 1'b0;
        model_mem[8] = 32'h5A5AC3C3;
        model_adr    = 8'h08;
        repeat (3) begin
            @(negedge clock);
            if (ack) acks++;
        end
        chk("b2b_acks", 32'(acks), 32'd3);
        chk("b2b_busy_low", 32'(low_cnt), 32'd2);
        chk("b2b_wr", 32'(wr_cnt - wr0), 32'd3);
        chk("b2b_idle", 32'(busy), 32'd0);
        chk("b2b_word", mem[8], model_mem[8]);

        for (int n = 0; n < 80; n++) begin
            rs = 2'($urandom_range(0, 3));
            ra = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) begin
                if (rs == 2'd1) ra[0] = 1'b0;
                if (rs == 2'd2) ra[1:0] = 2'b00;
            end
            run_txn(1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)), ra, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
